imem_port_arbiter: RTL and testbench

Shares the single-port, synchronous-read instruction memory between the fetch stage and a program-loader/debug requester. Fetch owns the port by default. The loader takes it over through a request/grant handshake, with a bounded burst length so fetch is never starved. While the loader owns the port, the arbiter stalls the PC and marks returned fetch data invalid so the fetch stage inserts bubbles. It sits between the PC/fetch logic and the IMEM macro.

---
 rtl/imem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_imem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - IMEM port arbiter between instruction fetch and loader/debug requester
module imem_port_arbiter #(
  parameter int IMEM_ADDR_WIDTH  = 10,
  parameter int IMEM_DATA_DEPTH  = 1024,
  parameter int MAX_LOADER_BURST = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        IF_Req,
  input  logic [31:0] IF_addr,
  input  logic        LD_Req,
  input  logic        LD_We,
  input  logic [31:0] LD_Addr,
  input  logic [31:0] LD_Wdata,
  output logic        LD_Gnt,
  output logic        LD_Rvalid,
  output logic [31:0] LD_Rdata,
  output logic        LD_Err,
  output logic [31:0] IMEM_addr,
  output logic        IMEM_we,
  output logic [31:0] IMEM_wdata,
  input  logic [31:0] IMEM_rdata,
  output logic [31:0] IF_Data,
  output logic        IF_Valid,
  output logic        Arb_Stall
);

  localparam int                  LP_CNT_W      = $clog2(MAX_LOADER_BURST + 1);
  localparam logic [LP_CNT_W-1:0] LP_MAX        = LP_CNT_W'(MAX_LOADER_BURST);
  localparam logic [LP_CNT_W-1:0] LP_MAX_M1     = LP_CNT_W'(MAX_LOADER_BURST - 1);
  localparam logic [31:0]         LP_BYTE_LIMIT = 32'(4 * IMEM_DATA_DEPTH);
  localparam int                  LP_HI         = IMEM_ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_LOAD     = 2'd1,
    ST_HANDBACK = 2'd2
  } state_t;

  state_t              r_state;
  logic [LP_CNT_W-1:0] r_burst_cnt;
  logic                r_yield_block;
  logic                r_if_valid;
  logic                r_ld_rvalid;

  logic w_in_fetch;
  logic w_in_load;
  logic w_in_handback;
  logic w_takeover;
  logic w_gnt;
  logic w_addr_ovf;
  logic w_drop;
  logic w_at_limit;
  logic w_forced_yield;

  assign w_in_fetch    = (r_state == ST_FETCH);
  assign w_in_load     = (r_state == ST_LOAD);
  assign w_in_handback = (r_state == ST_HANDBACK);

  assign w_takeover = w_in_fetch & LD_Req & ~r_yield_block;
  assign w_gnt      = w_in_load & LD_Req;

  // Any byte address beyond the word-index span or the populated depth is rejected.
  assign w_addr_ovf = |(LD_Addr >> LP_HI);
  assign w_drop     = (LD_Addr[1:0] != 2'b00) | w_addr_ovf | (LD_Addr >= LP_BYTE_LIMIT);

  // The grant in flight this cycle counts toward the limit, so the yield lands on the last allowed grant.
  assign w_at_limit     = (r_burst_cnt == LP_MAX) | (w_gnt & (r_burst_cnt == LP_MAX_M1));
  assign w_forced_yield = w_gnt & w_at_limit & IF_Req;

  assign LD_Gnt     = w_gnt;
  assign LD_Err     = w_gnt & w_drop;
  assign IMEM_we    = w_gnt & LD_We & ~w_drop;
  assign IMEM_addr  = w_in_load ? LD_Addr : IF_addr;
  assign IMEM_wdata = LD_Wdata;
  assign LD_Rdata   = IMEM_rdata;
  assign IF_Data    = IMEM_rdata;
  assign IF_Valid   = r_if_valid;
  assign LD_Rvalid  = r_ld_rvalid;
  assign Arb_Stall  = Reset_n & (w_takeover | w_in_load | w_in_handback);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= ST_FETCH;
      r_burst_cnt   <= '0;
      r_yield_block <= 1'b0;
      r_if_valid    <= 1'b0;
      r_ld_rvalid   <= 1'b0;
    end else begin
      r_if_valid  <= (w_in_fetch & ~w_takeover & IF_Req) | w_in_handback;
      r_ld_rvalid <= w_gnt & ~LD_We;

      case (r_state)
        ST_FETCH: begin
          if (IF_Req) begin
            r_yield_block <= 1'b0;
          end
          if (w_takeover) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_gnt && (r_burst_cnt != LP_MAX)) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end
          if (!LD_Req) begin
            r_state     <= ST_HANDBACK;
            r_burst_cnt <= '0;
          end else if (w_forced_yield) begin
            r_state       <= ST_HANDBACK;
            r_burst_cnt   <= '0;
            r_yield_block <= 1'b1;
          end
        end
        ST_HANDBACK: begin
          r_state <= ST_FETCH;
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - scoreboard bench for imem_port_arbiter with a behavioural IMEM
module tb_imem_port_arbiter;

  logic        Clk;
  logic        Reset_n;
  logic        IF_Req;
  logic [31:0] IF_addr;
  logic        LD_Req;
  logic        LD_We;
  logic [31:0] LD_Addr;
  logic [31:0] LD_Wdata;
  logic        LD_Gnt;
  logic        LD_Rvalid;
  logic [31:0] LD_Rdata;
  logic        LD_Err;
  logic [31:0] IMEM_addr;
  logic        IMEM_we;
  logic [31:0] IMEM_wdata;
  logic [31:0] imem_rdata;
  logic [31:0] IF_Data;
  logic        IF_Valid;
  logic        Arb_Stall;

  imem_port_arbiter #(
    .IMEM_ADDR_WIDTH (10),
    .IMEM_DATA_DEPTH (1024),
    .MAX_LOADER_BURST(4)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .IF_Req    (IF_Req),
    .IF_addr   (IF_addr),
    .LD_Req    (LD_Req),
    .LD_We     (LD_We),
    .LD_Addr   (LD_Addr),
    .LD_Wdata  (LD_Wdata),
    .LD_Gnt    (LD_Gnt),
    .LD_Rvalid (LD_Rvalid),
    .LD_Rdata  (LD_Rdata),
    .LD_Err    (LD_Err),
    .IMEM_addr (IMEM_addr),
    .IMEM_we   (IMEM_we),
    .IMEM_wdata(IMEM_wdata),
    .IMEM_rdata(imem_rdata),
    .IF_Data   (IF_Data),
    .IF_Valid  (IF_Valid),
    .Arb_Stall (Arb_Stall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] pat(int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Behavioural single-port IMEM: synchronous read, 1-cycle latency, preloaded on the first edge.
  logic [31:0] mem [0:1023];
  bit          init_done = 1'b0;
  always @(posedge Clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
      init_done <= 1'b1;
    end else if (IMEM_we) begin
      mem[IMEM_addr[11:2]] <= IMEM_wdata;
    end
    imem_rdata <= mem[IMEM_addr[11:2]];
  end

  typedef struct {
    bit          ifr;
    logic [31:0] ifa;
    bit          ldr;
    bit          ldw;
    logic [31:0] lda;
    logic [31:0] ldd;
    bit          ld;
    bit          stl;
    bit          gnt;
    bit          err;
    bit          we;
    bit          fv;
  } vec_t;

  typedef struct {
    bit          chk;
    logic [31:0] data;
  } ldexp_t;

  vec_t        vq[$];
  logic [31:0] exp_if[$];
  ldexp_t      exp_ld[$];
  logic [31:0] ref_mem [0:1023];
  int          checks = 0;
  int          errors = 0;
  int          gnt_seen = 0;
  bit          p_fv = 1'b0;
  bit          p_rv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  task automatic addv(input bit ifr, input logic [31:0] ifa, input bit ldr, input bit ldw,
                      input logic [31:0] lda, input logic [31:0] ldd, input bit ld, input bit stl,
                      input bit gnt, input bit err, input bit we, input bit fv);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.ldr = ldr; v.ldw = ldw; v.lda = lda; v.ldd = ldd;
    v.ld = ld; v.stl = stl; v.gnt = gnt; v.err = err; v.we = we; v.fv = fv;
    vq.push_back(v);
  endtask

  task automatic run_vecs();
    vec_t   c;
    ldexp_t e;
    while (vq.size() > 0) begin
      c = vq.pop_front();
      @(posedge Clk);
      #1;
      IF_Req = c.ifr; IF_addr = c.ifa;
      LD_Req = c.ldr; LD_We = c.ldw; LD_Addr = c.lda; LD_Wdata = c.ldd;
      if (c.we) ref_mem[c.lda[11:2]] = c.ldd;
      if (c.fv) exp_if.push_back(ref_mem[c.ifa[11:2]]);
      if (c.gnt && !c.ldw) begin
        e.chk = !c.err;
        e.data = ref_mem[c.lda[11:2]];
        exp_ld.push_back(e);
      end
      #2;
      chk("arb_stall", 32'(Arb_Stall), 32'(c.stl));
      chk("ld_gnt", 32'(LD_Gnt), 32'(c.gnt));
      chk("ld_err", 32'(LD_Err), 32'(c.err));
      chk("imem_we", 32'(IMEM_we), 32'(c.we));
      chk("imem_addr", IMEM_addr, c.ld ? c.lda : c.ifa);
      chk("if_valid", 32'(IF_Valid), 32'(p_fv));
      chk("ld_rvalid", 32'(LD_Rvalid), 32'(p_rv));
      if (c.we) chk("imem_wdata", IMEM_wdata, c.ldd);
      if (LD_Gnt === 1'b1) gnt_seen++;
      p_fv = c.fv;
      p_rv = c.gnt & ~c.ldw;
    end
  endtask

  task automatic monitor();
    ldexp_t e;
    forever begin
      @(negedge Clk);
      if (IF_Valid === 1'b1) begin
        if (exp_if.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_data_unexpected actual=%h required=none @%0t", IF_Data, $time);
        end else begin
          chk("if_data", IF_Data, exp_if.pop_front());
        end
      end
      if (LD_Rvalid === 1'b1) begin
        if (exp_ld.size() == 0) begin
          checks++; errors++;
          $display("FAIL ld_rdata_unexpected actual=%h required=none @%0t", LD_Rdata, $time);
        end else begin
          e = exp_ld.pop_front();
          if (e.chk) chk("ld_rdata", LD_Rdata, e.data);
        end
      end
    end
  endtask

  initial begin
    Reset_n = 1'b0; IF_Req = 1'b1; IF_addr = 32'h44;
    LD_Req = 1'b1; LD_We = 1'b1; LD_Addr = 32'h100; LD_Wdata = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
    fork
      monitor();
    join_none

    repeat (2) @(posedge Clk);
    #2;
    chk("rst_arb_stall", 32'(Arb_Stall), 32'h0);
    chk("rst_ld_gnt", 32'(LD_Gnt), 32'h0);
    chk("rst_ld_err", 32'(LD_Err), 32'h0);
    chk("rst_imem_we", 32'(IMEM_we), 32'h0);
    chk("rst_imem_addr", IMEM_addr, 32'h44);
    chk("rst_if_valid", 32'(IF_Valid), 32'h0);
    chk("rst_ld_rvalid", 32'(LD_Rvalid), 32'h0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1; LD_Req = 1'b0; IF_Req = 1'b0;

    // plain fetch
    addv(1, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1);
    addv(1, 32'h4, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1);
    addv(1, 32'h8, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1);
    // three loader writes, then read one back through fetch
    addv(1, 32'hC, 1, 1, 32'h100, 32'hA1, 0, 1, 0, 0, 0, 0);
    addv(1, 32'hC, 1, 1, 32'h100, 32'hA1, 1, 1, 1, 0, 1, 0);
    addv(1, 32'hC, 1, 1, 32'h104, 32'hA2, 1, 1, 1, 0, 1, 0);
    addv(1, 32'hC, 1, 1, 32'h108, 32'hA3, 1, 1, 1, 0, 1, 0);
    addv(1, 32'hC, 0, 0, 32'h108, 32'h0, 1, 1, 0, 0, 0, 0);
    addv(1, 32'hC, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0, 0, 1);
    addv(1, 32'h10, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1);
    addv(1, 32'h100, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1);
    // write then read 0x200
    addv(1, 32'h14, 1, 1, 32'h200, 32'hDEADBEEF, 0, 1, 0, 0, 0, 0);
    addv(1, 32'h14, 1, 1, 32'h200, 32'hDEADBEEF, 1, 1, 1, 0, 1, 0);
    addv(1, 32'h14, 1, 0, 32'h200, 32'h0, 1, 1, 1, 0, 0, 0);
    addv(1, 32'h14, 0, 0, 32'h200, 32'h0, 1, 1, 0, 0, 0, 0);
    addv(1, 32'h14, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0, 0, 1);
    addv(1, 32'h18, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1);
    // misaligned and out-of-range writes are dropped; word 0 must stay intact
    addv(1, 32'h1C, 1, 1, 32'h1002, 32'hBAD1, 0, 1, 0, 0, 0, 0);
    addv(1, 32'h1C, 1, 1, 32'h1002, 32'hBAD1, 1, 1, 1, 1, 0, 0);
    addv(1, 32'h1C, 1, 1, 32'h1000, 32'hBAD2, 1, 1, 1, 1, 0, 0);
    addv(1, 32'h1C, 0, 0, 32'h1000, 32'h0, 1, 1, 0, 0, 0, 0);
    addv(1, 32'h1C, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0, 0, 1);
    addv(1, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1);
    run_vecs();

    // ten loader writes with fetch requesting: yields after 4 and 8 grants
    gnt_seen = 0;
    addv(1, 32'h24, 1, 1, 32'h300, 32'h5000_0000, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      addv(1, 32'h24, 1, 1, 32'h300 + 32'(4 * k), 32'h5000_0000 + 32'(k), 1, 1, 1, 0, 1, 0);
    addv(1, 32'h24, 1, 1, 32'h310, 32'h5000_0004, 0, 1, 0, 0, 0, 1);
    addv(1, 32'h28, 1, 1, 32'h310, 32'h5000_0004, 0, 0, 0, 0, 0, 1);
    addv(1, 32'h2C, 1, 1, 32'h310, 32'h5000_0004, 0, 1, 0, 0, 0, 0);
    for (int k = 4; k < 8; k++)
      addv(1, 32'h2C, 1, 1, 32'h300 + 32'(4 * k), 32'h5000_0000 + 32'(k), 1, 1, 1, 0, 1, 0);
    addv(1, 32'h2C, 1, 1, 32'h320, 32'h5000_0008, 0, 1, 0, 0, 0, 1);
    addv(1, 32'h30, 1, 1, 32'h320, 32'h5000_0008, 0, 0, 0, 0, 0, 1);
    addv(1, 32'h34, 1, 1, 32'h320, 32'h5000_0008, 0, 1, 0, 0, 0, 0);
    for (int k = 8; k < 10; k++)
      addv(1, 32'h34, 1, 1, 32'h300 + 32'(4 * k), 32'h5000_0000 + 32'(k), 1, 1, 1, 0, 1, 0);
    addv(1, 32'h34, 0, 0, 32'h324, 32'h0, 1, 1, 0, 0, 0, 0);
    addv(1, 32'h34, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0, 0, 1);
    addv(1, 32'h300, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1);
    addv(1, 32'h324, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1);
    run_vecs();
    chk("burst_grants", 32'(gnt_seen), 32'd10);

    // fetch idle at the limit: loader continues, count saturates, yield once fetch asks
    addv(0, 32'h38, 1, 1, 32'h400, 32'h6000_0000, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++)
      addv(0, 32'h38, 1, 1, 32'h400 + 32'(4 * k), 32'h6000_0000 + 32'(k), 1, 1, 1, 0, 1, 0);
    addv(1, 32'h38, 1, 1, 32'h418, 32'h6000_0006, 1, 1, 1, 0, 1, 0);
    addv(1, 32'h38, 1, 0, 32'h41C, 32'h0, 0, 1, 0, 0, 0, 1);
    addv(1, 32'h3C, 1, 0, 32'h41C, 32'h0, 0, 0, 0, 0, 0, 1);
    addv(1, 32'h40, 1, 0, 32'h41C, 32'h0, 0, 1, 0, 0, 0, 0);
    addv(1, 32'h40, 1, 0, 32'h41C, 32'h0, 1, 1, 1, 0, 0, 0);
    run_vecs();

    // asynchronous reset in the middle of a loader burst
    @(posedge Clk);
    #1;
    IF_Req = 1'b1; IF_addr = 32'h44; LD_Req = 1'b1; LD_We = 1'b0; LD_Addr = 32'h420;
    #1;
    chk("pre_rst_ld_gnt", 32'(LD_Gnt), 32'h1);
    chk("pre_rst_ld_rvalid", 32'(LD_Rvalid), 32'(p_rv));
    Reset_n = 1'b0;
    exp_ld.delete();
    #1;
    chk("mid_rst_arb_stall", 32'(Arb_Stall), 32'h0);
    chk("mid_rst_ld_gnt", 32'(LD_Gnt), 32'h0);
    chk("mid_rst_imem_we", 32'(IMEM_we), 32'h0);
    chk("mid_rst_ld_err", 32'(LD_Err), 32'h0);
    chk("mid_rst_ld_rvalid", 32'(LD_Rvalid), 32'h0);
    chk("mid_rst_if_valid", 32'(IF_Valid), 32'h0);
    chk("mid_rst_imem_addr", IMEM_addr, 32'h44);
    @(negedge Clk);
    Reset_n = 1'b1; LD_Req = 1'b0; IF_Req = 1'b0;
    p_fv = 1'b0; p_rv = 1'b0;

    // after release the arbiter is in FETCH: takeover bubble precedes the first grant
    addv(1, 32'h48, 1, 1, 32'h500, 32'h77, 0, 1, 0, 0, 0, 0);
    addv(1, 32'h48, 1, 1, 32'h500, 32'h77, 1, 1, 1, 0, 1, 0);
    addv(1, 32'h48, 0, 0, 32'h500, 32'h0, 1, 1, 0, 0, 0, 0);
    addv(1, 32'h48, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0, 0, 1);
    addv(1, 32'h500, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1);
    addv(0, 32'h4C, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    run_vecs();

    repeat (2) @(negedge Clk);
    #1;
    chk("if_queue_drained", 32'(exp_if.size()), 32'h0);
    chk("ld_queue_drained", 32'(exp_ld.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
